fpnew_slice_share_arbiter: RTL and testbench
============================================

# fpnew_slice_share_arbiter

Shares one operation-group format slice between `NumReq` independent requesters, such as issue ports or harts. A round-robin arbiter with grant locking decides which request goes to the slice. An in-order ID FIFO records the owner of every in-flight operation so each result and status is routed back to the requester that issued it. The block sits between the issue logic and a single slice instance; the slice completes operations in issue order.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, ≥2.
- `DataWidth`, 128: width of the opaque request bundle (operands, op, op_mod, rnd_mode, vectorial flag, tag), forwarded unchanged.
- `Width`, 32: result width.
- `MaxInflight`, 4: ID FIFO depth, i.e. the maximum number of accepted but not yet returned operations. Must be ≥ the slice pipeline depth + 1 for full throughput.

Ports:
- `clk_i`, in, 1: clock. One clock domain.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `flush_i`, in, 1: kills all in-flight operations.
- `req_valid_i`, in, `NumReq`: per-requester valid.
- `req_ready_o`, out, `NumReq`: per-requester ready.
- `req_data_i`, in, `NumReq`×`DataWidth`: per-requester bundle.
- `slc_valid_o`, out, 1: request valid to the slice.
- `slc_ready_i`, in, 1: slice input ready.
- `slc_data_o`, out, `DataWidth`: bundle of the granted requester.
- `slc_flush_o`, out, 1: flush to the slice.
- `slc_valid_i`, in, 1: slice result valid.
- `slc_ready_o`, out, 1: ready to the slice output.
- `slc_result_i`, in, `Width`: slice result.
- `slc_status_i`, in, 5: slice status flags.
- `rsp_valid_o`, out, `NumReq`: per-requester response valid, one-hot or zero.
- `rsp_ready_i`, in, `NumReq`: per-requester response ready.
- `rsp_result_o`, out, `Width`: response result, shared by all requesters.
- `rsp_status_o`, out, 5: response status, shared by all requesters.
- `inflight_o`, out, `$clog2(MaxInflight+1)`: current ID FIFO occupancy.
- `busy_o`, out, 1: high when `inflight_o` ≠ 0 or any `req_valid_i` is high.

## Operation
State:
- `rr_ptr`: index of the highest-priority requester. Reset value 0.
- `lock` and `lock_id`: grant lock. Reset value unlocked.
- ID FIFO of `MaxInflight` entries, each `$clog2(NumReq)` bits wide, plus an occupancy counter.

Arbitration:
- Requesters are scanned starting at `rr_ptr` and wrapping around; the first one with `req_valid_i` set wins.
- `slc_valid_o` = a winner exists && FIFO not full && !`flush_i`.
- `slc_data_o` = `req_data_i[winner]`.
- `req_ready_o[winner]` = `slc_ready_i` && FIFO not full && !`flush_i`. All other `req_ready_o` bits are 0.

Grant lock:
- If `slc_valid_o` && !`slc_ready_i`, set `lock` and store the winner in `lock_id`.
- While locked, the winner is forced to `lock_id` regardless of priority.
- The lock clears on the accepting handshake or on flush.

Accept (`slc_valid_o` && `slc_ready_i`):
- Push the winner ID into the FIFO.
- `rr_ptr` ← (winner+1) mod `NumReq`.

Response routing:
- head = FIFO head ID.
- `rsp_valid_o[head]` = `slc_valid_i` && FIFO not empty && !`flush_i`.
- `slc_ready_o` = `rsp_ready_i[head]` && FIFO not empty.
- `rsp_result_o` and `rsp_status_o` pass through combinationally from the slice.
- Pop the FIFO on `slc_valid_i` && `slc_ready_o`.

Boundary conditions:
- FIFO full: no new grant. A pop in the same cycle does not enable a push; fullness is evaluated on registered occupancy.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance, wrapping modulo `MaxInflight`.
- `slc_valid_i` while the FIFO is empty: a protocol error. Suppress it, drop no state, and keep `slc_ready_o` = 0.
- `flush_i`:
  - `slc_flush_o` = `flush_i` combinationally.
  - The FIFO is emptied at the next edge and the lock clears.
  - `rr_ptr` is kept.
  - No handshake on either side occurs in the flush cycle.
- `rst_i` mid-operation: all state returns to reset values at the next edge. In-flight IDs are discarded; the slice must be reset or flushed together with this block.
- Reset values of outputs: all valids and readies 0; `inflight_o` = 0; `busy_o` = OR of `req_valid_i`; `slc_flush_o` follows `flush_i`.

## Timing
- Request path has zero added latency: `req_*` → `slc_*` is combinational, with the grant computed from registered `rr_ptr`, `lock` and occupancy.
- Response path has zero added latency: `slc_*` → `rsp_*` is combinational.
- No combinational path from `slc_ready_i` to `slc_valid_o`. A path from `rsp_ready_i` to `slc_ready_o` exists.
- Throughput: one accept and one return per cycle when the FIFO is neither full nor empty.
- FIFO and pointer updates take effect at the clock edge after the handshake.

## Test plan
- Round-robin fairness: `NumReq`=2, both requesters continuously valid, `slc_ready_i`=1 → grants alternate 0,1,0,1. Results are returned to ports 0,1,0,1 in issue order.
- Grant lock: requester 1 valid with `slc_ready_i`=0 for 3 cycles, requester 0 asserts valid in cycle 2 → `slc_data_o` stays on requester 1 until ready, then requester 0 is granted next.
- Full FIFO: `MaxInflight`=4, slice holds all results → exactly 4 accepts, then `req_ready_o`=0 and `inflight_o`=4. One pop → the next accept happens one cycle later.
- Response backpressure: head ID=1 with `rsp_ready_i[1]`=0 and `rsp_ready_i[0]`=1 → `slc_ready_o`=0 and the result is held. Raising `rsp_ready_i[1]` pops the entry and decrements `inflight_o`.
- Flush with 3 operations in flight → `slc_flush_o`=1 in the same cycle, no `rsp_valid_o` in that cycle, `inflight_o`=0 at the next edge, and a new request is accepted the cycle after.
- Synchronous reset asserted while 2 operations are in flight → at the next edge `inflight_o`=0, `rr_ptr`=0 and all valids are 0.

Source files
------------

// File: rtl/fpnew_slice_share_arbiter_if.sv
// Handshake bundle between the requesters, the shared format slice and the
// slice-share arbiter. The master modport is the arbiter's view; slave is the environment's.
interface fpnew_slice_share_arbiter_if #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned Width       = 32,
    parameter int unsigned MaxInflight = 4
);
    localparam int unsigned CntW = $clog2(MaxInflight + 1);

    logic                                flush_i;
    logic [NumReq-1:0]                   req_valid_i;
    logic [NumReq-1:0]                   req_ready_o;
    logic [NumReq-1:0][DataWidth-1:0]    req_data_i;
    logic                                slc_valid_o;
    logic                                slc_ready_i;
    logic [DataWidth-1:0]                slc_data_o;
    logic                                slc_flush_o;
    logic                                slc_valid_i;
    logic                                slc_ready_o;
    logic [Width-1:0]                    slc_result_i;
    logic [4:0]                          slc_status_i;
    logic [NumReq-1:0]                   rsp_valid_o;
    logic [NumReq-1:0]                   rsp_ready_i;
    logic [Width-1:0]                    rsp_result_o;
    logic [4:0]                          rsp_status_o;
    logic [CntW-1:0]                     inflight_o;
    logic                                busy_o;

    modport master (
        input  flush_i, req_valid_i, req_data_i, slc_ready_i, slc_valid_i,
               slc_result_i, slc_status_i, rsp_ready_i,
        output req_ready_o, slc_valid_o, slc_data_o, slc_flush_o, slc_ready_o,
               rsp_valid_o, rsp_result_o, rsp_status_o, inflight_o, busy_o
    );

    modport slave (
        output flush_i, req_valid_i, req_data_i, slc_ready_i, slc_valid_i,
               slc_result_i, slc_status_i, rsp_ready_i,
        input  req_ready_o, slc_valid_o, slc_data_o, slc_flush_o, slc_ready_o,
               rsp_valid_o, rsp_result_o, rsp_status_o, inflight_o, busy_o
    );
endinterface

// File: rtl/fpnew_slice_share_arbiter.sv
// Shares one in-order format slice between NumReq requesters: round-robin grant with
// a lock that holds a stalled offer, plus an ID FIFO that routes results back to their owner.
module fpnew_slice_share_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned Width       = 32,
    parameter int unsigned MaxInflight = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    fpnew_slice_share_arbiter_if.master bus
);
    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
    localparam int unsigned CntW = $clog2(MaxInflight + 1);

    typedef logic [IdW-1:0]  id_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    // Registered state
    id_t  rr_ptr_q,  rr_ptr_d;
    logic lock_q,    lock_d;
    id_t  lock_id_q, lock_id_d;
    ptr_t wr_ptr_q,  wr_ptr_d;
    ptr_t rd_ptr_q,  rd_ptr_d;
    cnt_t cnt_q,     cnt_d;
    id_t  fifo_q [MaxInflight];
    id_t  fifo_d [MaxInflight];

    // Combinational decode
    logic                 win_found;
    id_t                  win_id;
    id_t                  scan_idx;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 grant_ok;
    logic                 accept;
    logic                 pop;
    id_t                  head_id;
    logic                 slc_ready;
    logic [NumReq-1:0]    req_ready;
    logic [NumReq-1:0]    rsp_valid;
    logic [DataWidth-1:0] slc_data;
    logic [Width-1:0]     rsp_result;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MaxInflight - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic id_t id_inc(input id_t id);
        return (id == id_t'(NumReq - 1)) ? '0 : id + id_t'(1);
    endfunction

    // Winner: the locked requester while an offer is stalled, otherwise the
    // first valid requester at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        if (lock_q) begin
            win_id    = lock_id_q;
            win_found = bus.req_valid_i[lock_id_q];
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                scan_idx = id_t'((32'(rr_ptr_q) + k) % NumReq);
                if (!win_found && bus.req_valid_i[scan_idx]) begin
                    win_found = 1'b1;
                    win_id    = scan_idx;
                end
            end
        end
    end

    // Fullness uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign fifo_full  = (cnt_q == cnt_t'(MaxInflight));
    assign fifo_empty = (cnt_q == '0);
    assign grant_ok   = win_found && !fifo_full && !bus.flush_i;
    assign accept     = grant_ok && bus.slc_ready_i;
    assign head_id    = fifo_q[rd_ptr_q];
    assign slc_ready  = !fifo_empty && bus.rsp_ready_i[head_id];
    assign pop        = bus.slc_valid_i && slc_ready && !bus.flush_i;
    assign slc_data   = bus.req_data_i[win_id];
    assign rsp_result = bus.slc_result_i;

    always_comb begin
        req_ready = '0;
        if (win_found && bus.slc_ready_i && !fifo_full && !bus.flush_i) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // A result with nothing in flight is a protocol error and is never forwarded.
    always_comb begin
        rsp_valid = '0;
        if (bus.slc_valid_i && !fifo_empty && !bus.flush_i) begin
            rsp_valid[head_id] = 1'b1;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.slc_valid_o  = grant_ok;
    assign bus.slc_data_o   = slc_data;
    assign bus.slc_flush_o  = bus.flush_i;
    assign bus.slc_ready_o  = slc_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_result_o = rsp_result;
    assign bus.rsp_status_o = bus.slc_status_i;
    assign bus.inflight_o   = cnt_q;
    assign bus.busy_o       = (cnt_q != '0) || (|bus.req_valid_i);

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        fifo_d    = fifo_q;
        if (bus.flush_i) begin
            // rr_ptr survives a flush; only in-flight bookkeeping is dropped.
            lock_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (accept) begin
                lock_d           = 1'b0;
                rr_ptr_d         = id_inc(win_id);
                fifo_d[wr_ptr_q] = win_id;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end else if (grant_ok) begin
                lock_d    = 1'b1;
                lock_id_d = win_id;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({accept, pop})
                2'b10:   cnt_d = cnt_q + cnt_t'(1);
                2'b01:   cnt_d = cnt_q - cnt_t'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // ID storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_fpnew_slice_share_arbiter.sv
// Randomized bench for fpnew_slice_share_arbiter against a queue-based model of the
// grant, ownership and routing rules.
module tb_fpnew_slice_share_arbiter;
    localparam int N  = 2;
    localparam int DW = 128;
    localparam int W  = 32;
    localparam int MI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpnew_slice_share_arbiter_if #(.NumReq(N), .DataWidth(DW), .Width(W), .MaxInflight(MI)) bus ();

    fpnew_slice_share_arbiter #(.NumReq(N), .DataWidth(DW), .Width(W), .MaxInflight(MI)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: owners of accepted-but-unreturned operations in issue order,
    // the next priority requester, and the requester whose offer is stalled (-1 if none).
    int             owners[$];
    int             rr      = 0;
    int             held    = -1;
    bit             pend[N];
    logic [DW-1:0]  pdata[N];

    function automatic bit roll(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic run_cycles(input int ncyc, input int p_req, input int p_sr, input int p_sv,
                              input int p_rr, input int p_fl, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            bit          found;
            int          w;
            bit          full;
            bit          e_sv;
            bit          e_sro;
            logic [N-1:0] e_rdy;
            logic [N-1:0] e_rv;
            logic [N-1:0] vld;

            @(negedge clk);
            rst = (c == rst_at);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && roll(p_req)) begin
                    pend[i]  = 1'b1;
                    pdata[i] = {$urandom, $urandom, $urandom, $urandom};
                end
                vld[i]               = pend[i];
                bus.req_data_i[i]    = pdata[i];
                bus.rsp_ready_i[i]   = roll(p_rr);
            end
            bus.req_valid_i  = vld;
            bus.slc_ready_i  = roll(p_sr);
            bus.slc_valid_i  = roll(p_sv);
            bus.slc_result_i = $urandom;
            bus.slc_status_i = 5'($urandom);
            bus.flush_i      = roll(p_fl);
            #1;

            found = 1'b0;
            w     = 0;
            if (held >= 0) begin
                w     = held;
                found = pend[w];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!found && pend[(rr + k) % N]) begin
                        found = 1'b1;
                        w     = (rr + k) % N;
                    end
                end
            end
            full  = (owners.size() == MI);
            e_sv  = found && !full && !bus.flush_i;
            e_rdy = '0;
            if (e_sv && bus.slc_ready_i) e_rdy[w] = 1'b1;
            e_rv  = '0;
            e_sro = 1'b0;
            if (owners.size() > 0) begin
                e_sro = bus.rsp_ready_i[owners[0]];
                if (bus.slc_valid_i && !bus.flush_i) e_rv[owners[0]] = 1'b1;
            end

            check_eq("slc_valid", bus.slc_valid_o, e_sv);
            check_eq("req_ready", bus.req_ready_o, e_rdy);
            if (found) check_eq("slc_data", bus.slc_data_o, pdata[w]);
            check_eq("slc_flush", bus.slc_flush_o, bus.flush_i);
            check_eq("rsp_valid", bus.rsp_valid_o, e_rv);
            check_eq("slc_ready_o", bus.slc_ready_o, e_sro);
            check_eq("rsp_result", bus.rsp_result_o, bus.slc_result_i);
            check_eq("rsp_status", bus.rsp_status_o, bus.slc_status_i);
            check_eq("inflight", bus.inflight_o, owners.size());
            check_eq("busy", bus.busy_o, (owners.size() != 0) || (|vld));

            if (rst) begin
                owners.delete();
                rr   = 0;
                held = -1;
                for (int i = 0; i < N; i++) pend[i] = 1'b0;
            end else if (bus.flush_i) begin
                owners.delete();
                held = -1;
            end else begin
                if (bus.slc_valid_i && e_sro) void'(owners.pop_front());
                if (e_sv && bus.slc_ready_i) begin
                    owners.push_back(w);
                    rr      = (w + 1) % N;
                    held    = -1;
                    pend[w] = 1'b0;
                end else if (e_sv) begin
                    held = w;
                end
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush_i      = 1'b1;
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.slc_ready_i  = 1'b0;
        bus.slc_valid_i  = 1'b0;
        bus.slc_result_i = '0;
        bus.slc_status_i = '0;
        bus.rsp_ready_i  = '0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_inflight",   bus.inflight_o, 0);
        check_eq("reset_slc_valid",  bus.slc_valid_o, 0);
        check_eq("reset_req_ready",  bus.req_ready_o, 0);
        check_eq("reset_rsp_valid",  bus.rsp_valid_o, 0);
        check_eq("reset_slc_ready",  bus.slc_ready_o, 0);
        check_eq("reset_busy",       bus.busy_o, 0);
        check_eq("reset_flush_pass", bus.slc_flush_o, 1);
        bus.flush_i = 1'b0;
        rst         = 1'b0;

        // Both requesters always valid, everything ready: alternating grants and returns.
        run_cycles(40, 100, 100, 100, 100, 0, -1);
        // Slice holds every result: the FIFO fills and stops granting.
        run_cycles(12, 100, 100, 0, 100, 0, -1);
        @(posedge clk);
        #1;
        check_eq("full_inflight",  bus.inflight_o, MI);
        check_eq("full_req_ready", bus.req_ready_o, 0);
        // Flush with a full FIFO and a pending result.
        run_cycles(1, 100, 100, 100, 100, 100, -1);
        // Mostly stalled slice input: exercises the grant lock.
        run_cycles(40, 60, 30, 50, 60, 0, -1);
        // Response backpressure heavy.
        run_cycles(40, 70, 80, 70, 20, 0, -1);
        // Put operations in flight, then reset in the middle of traffic.
        run_cycles(6, 100, 100, 0, 100, 0, -1);
        run_cycles(1, 0, 100, 0, 100, 0, 0);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.req_valid_i = '0;
        bus.slc_valid_i = 1'b0;
        #1;
        check_eq("rst_inflight",  bus.inflight_o, 0);
        check_eq("rst_slc_valid", bus.slc_valid_o, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
        check_eq("rst_slc_ready", bus.slc_ready_o, 0);
        // Requester 1 alone first after reset must still leave rr_ptr at 0 semantics to the model.
        run_cycles(400, 50, 60, 60, 60, 3, -1);
        run_cycles(300, 85, 85, 50, 40, 2, 150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
